// File: rtl/gowin_tlcfg_pkg.sv
// Shared translation-layer config defines plus the types and helpers used by the
// Gowin TL_CFG source.
`ifndef GOWIN_TLCFG_DEFS
`define GOWIN_TLCFG_DEFS
`define SIG_CFG_ADD_W      4
`define SIG_CFG_CTL_W      32
`define SIG_CFG_STS_W      53
`define TLCFG_DEVCTL_I     4'd0
`define TLCFG_LNKCTL_I     4'd2
`define TLCFG_PRMCMD_I     4'd3
`define TLCFG_MSICSR_I     4'd13
`define TLCFG_BUSDEV_I     4'd15
`define TLCTL_MAXREQ_R     30:28
`define TLCTL_MAXPAY_R     23:21
`define TLCTL_RCB_R        19
`define TLCTL_BUSMSTR_R    26
`define TLCTL_MSIENABLE_R  0
`define TLCTL_BUSDEV_R     12:0
`define TLSTS_LWIDTH_R     40:35
`define TLSTS_LRATE_R      34:31
`endif

package gowin_tlcfg_pkg;

  localparam int unsigned CFG_ADD_W = `SIG_CFG_ADD_W;
  localparam int unsigned CFG_CTL_W = `SIG_CFG_CTL_W;
  localparam int unsigned CFG_STS_W = `SIG_CFG_STS_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    DROP = 2'd3
  } msi_state_t;

  typedef struct packed {
    logic [7:0] bus_num;
    logic [4:0] dev_num;
    logic [2:0] max_payload;
    logic [2:0] max_read_req;
    logic       rcb;
    logic       bus_master_en;
    logic       msi_enable;
    logic [5:0] link_width;
    logic [3:0] link_rate;
  } core_cfg_t;

  // CTL payload for a given config index; unlisted indices and bits are zero.
  function automatic logic [CFG_CTL_W-1:0] cfg_ctl_word(input logic [CFG_ADD_W-1:0] idx,
                                                        input core_cfg_t c);
    logic [CFG_CTL_W-1:0] w;
    w = '0;
    case (idx)
      `TLCFG_DEVCTL_I: begin
        w[`TLCTL_MAXREQ_R] = c.max_read_req;
        w[`TLCTL_MAXPAY_R] = c.max_payload;
      end
      `TLCFG_LNKCTL_I: w[`TLCTL_RCB_R]       = c.rcb;
      `TLCFG_PRMCMD_I: w[`TLCTL_BUSMSTR_R]   = c.bus_master_en;
      `TLCFG_MSICSR_I: w[`TLCTL_MSIENABLE_R] = c.msi_enable;
      `TLCFG_BUSDEV_I: w[`TLCTL_BUSDEV_R]    = {c.bus_num, c.dev_num};
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [CFG_STS_W-1:0] cfg_sts_word(input core_cfg_t c);
    logic [CFG_STS_W-1:0] w;
    w = '0;
    w[`TLSTS_LWIDTH_R] = c.link_width;
    w[`TLSTS_LRATE_R]  = c.link_rate;
    return w;
  endfunction

endpackage

// File: rtl/gowin_tlcfg_source_msi.sv
// MSI request/acknowledge handshake between the translation layer and the
// Gowin core's native MSI port, with a grant timeout.
module gowin_msi_handshake
  import gowin_tlcfg_pkg::*;
#(
  parameter int unsigned C_MSI_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic app_req,
  input  logic msi_en,
  input  logic core_gnt,
  output logic core_req,
  output logic app_ack,
  output logic timeout_err
);

  localparam int unsigned CNT_W = 16;

  msi_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              timeout_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      core_req    <= 1'b0;
      app_ack     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      core_req    <= (state_nxt == REQ);
      app_ack     <= (state_nxt == ACK);
      timeout_err <= timeout_err | timeout_fire;
    end
  end

  // Grant is checked before the timeout so a last-cycle grant still acks.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    timeout_fire = 1'b0;
    case (state)
      IDLE: begin
        if (app_req && msi_en) begin
          state_nxt = REQ;
          cnt_nxt   = '0;
        end
      end
      REQ: begin
        if (core_gnt) begin
          state_nxt = ACK;
        end else if (cnt == CNT_W'(C_MSI_TIMEOUT - 1)) begin
          state_nxt    = DROP;
          timeout_fire = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ACK:  state_nxt = DROP;
      DROP: if (!app_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/gowin_tlcfg_source.sv
// Serialises the Gowin core's flat config/status into the time-multiplexed
// TL_CFG_ADD/CTL/STS stream and bridges the MSI handshake.
module gowin_tlcfg_source
  import gowin_tlcfg_pkg::*;
#(
  parameter int unsigned C_HOLD_CYCLES = 8,
  parameter int unsigned C_MSI_TIMEOUT = 1024
) (
  input  logic                 CLK,
  input  logic                 RST_IN,
  input  logic [7:0]           CORE_BUS_NUM,
  input  logic [4:0]           CORE_DEV_NUM,
  input  logic [2:0]           CORE_MAX_PAYLOAD,
  input  logic [2:0]           CORE_MAX_READ_REQ,
  input  logic                 CORE_RCB,
  input  logic                 CORE_BUS_MASTER_EN,
  input  logic                 CORE_MSI_ENABLE,
  input  logic [5:0]           CORE_LINK_WIDTH,
  input  logic [3:0]           CORE_LINK_RATE,
  output logic                 CORE_MSI_REQ,
  input  logic                 CORE_MSI_GNT,
  output logic [CFG_ADD_W-1:0] TL_CFG_ADD,
  output logic [CFG_CTL_W-1:0] TL_CFG_CTL,
  output logic [CFG_STS_W-1:0] TL_CFG_STS,
  input  logic                 APP_MSI_REQ,
  output logic                 APP_MSI_ACK,
  output logic                 MSI_TIMEOUT_ERR
);

  localparam int unsigned HOLD_W = 8;

  core_cfg_t             cfg_q;
  logic [HOLD_W-1:0]     hold_cnt;
  logic                  hold_tc;
  logic [CFG_ADD_W-1:0]  add_nxt;

  always_ff @(posedge CLK or posedge RST_IN) begin
    if (RST_IN) begin
      cfg_q <= '0;
    end else begin
      cfg_q.bus_num       <= CORE_BUS_NUM;
      cfg_q.dev_num       <= CORE_DEV_NUM;
      cfg_q.max_payload   <= CORE_MAX_PAYLOAD;
      cfg_q.max_read_req  <= CORE_MAX_READ_REQ;
      cfg_q.rcb           <= CORE_RCB;
      cfg_q.bus_master_en <= CORE_BUS_MASTER_EN;
      cfg_q.msi_enable    <= CORE_MSI_ENABLE;
      cfg_q.link_width    <= CORE_LINK_WIDTH;
      cfg_q.link_rate     <= CORE_LINK_RATE;
    end
  end

  assign hold_tc = (hold_cnt == HOLD_W'(C_HOLD_CYCLES - 1));
  assign add_nxt = hold_tc ? TL_CFG_ADD + CFG_ADD_W'(1) : TL_CFG_ADD;

  // CTL is built from the next index so ADD and CTL always change together.
  always_ff @(posedge CLK or posedge RST_IN) begin
    if (RST_IN) begin
      hold_cnt   <= '0;
      TL_CFG_ADD <= '0;
      TL_CFG_CTL <= '0;
      TL_CFG_STS <= '0;
    end else begin
      hold_cnt   <= hold_tc ? '0 : hold_cnt + HOLD_W'(1);
      TL_CFG_ADD <= add_nxt;
      TL_CFG_CTL <= cfg_ctl_word(add_nxt, cfg_q);
      TL_CFG_STS <= cfg_sts_word(cfg_q);
    end
  end

  gowin_msi_handshake #(
    .C_MSI_TIMEOUT(C_MSI_TIMEOUT)
  ) u_msi (
    .clk         (CLK),
    .rst         (RST_IN),
    .app_req     (APP_MSI_REQ),
    .msi_en      (cfg_q.msi_enable),
    .core_gnt    (CORE_MSI_GNT),
    .core_req    (CORE_MSI_REQ),
    .app_ack     (APP_MSI_ACK),
    .timeout_err (MSI_TIMEOUT_ERR)
  );

endmodule

// File: tb/tb_gowin_tlcfg_source.sv
// Directed, table-driven bench for gowin_tlcfg_source: config sweep, STS,
// MSI handshake, timeout, grant/timeout race and asynchronous reset.
module tb_gowin_tlcfg_source;

  localparam int unsigned HOLD = 8;
  localparam int unsigned TMO  = 16;

  typedef struct {
    logic [7:0]  bus;
    logic [4:0]  dev;
    logic [2:0]  mp;
    logic [2:0]  mr;
    logic        rcb;
    logic        bm;
    logic        me;
    logic [5:0]  lw;
    logic [3:0]  lr;
    logic [31:0] e_dev;
    logic [31:0] e_lnk;
    logic [31:0] e_cmd;
    logic [31:0] e_msi;
    logic [31:0] e_bd;
    logic [52:0] e_sts;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  bus_num = '0;
  logic [4:0]  dev_num = '0;
  logic [2:0]  max_payload = '0;
  logic [2:0]  max_read_req = '0;
  logic        rcb = 1'b0;
  logic        bus_master_en = 1'b0;
  logic        msi_enable = 1'b0;
  logic [5:0]  link_width = '0;
  logic [3:0]  link_rate = '0;
  logic        core_msi_req;
  logic        core_msi_gnt = 1'b0;
  logic [3:0]  tl_cfg_add;
  logic [31:0] tl_cfg_ctl;
  logic [52:0] tl_cfg_sts;
  logic        app_msi_req = 1'b0;
  logic        app_msi_ack;
  logic        msi_timeout_err;

  int checks = 0;
  int failures = 0;
  vec_t vecs [4];

  always #5 clk = ~clk;

  gowin_tlcfg_source #(
    .C_HOLD_CYCLES(HOLD),
    .C_MSI_TIMEOUT(TMO)
  ) dut (
    .CLK               (clk),
    .RST_IN            (rst),
    .CORE_BUS_NUM      (bus_num),
    .CORE_DEV_NUM      (dev_num),
    .CORE_MAX_PAYLOAD  (max_payload),
    .CORE_MAX_READ_REQ (max_read_req),
    .CORE_RCB          (rcb),
    .CORE_BUS_MASTER_EN(bus_master_en),
    .CORE_MSI_ENABLE   (msi_enable),
    .CORE_LINK_WIDTH   (link_width),
    .CORE_LINK_RATE    (link_rate),
    .CORE_MSI_REQ      (core_msi_req),
    .CORE_MSI_GNT      (core_msi_gnt),
    .TL_CFG_ADD        (tl_cfg_add),
    .TL_CFG_CTL        (tl_cfg_ctl),
    .TL_CFG_STS        (tl_cfg_sts),
    .APP_MSI_REQ       (app_msi_req),
    .APP_MSI_ACK       (app_msi_ack),
    .MSI_TIMEOUT_ERR   (msi_timeout_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input vec_t v);
    bus_num = v.bus; dev_num = v.dev; max_payload = v.mp; max_read_req = v.mr;
    rcb = v.rcb; bus_master_en = v.bm; msi_enable = v.me;
    link_width = v.lw; link_rate = v.lr;
  endtask

  function automatic logic [31:0] exp_ctl(input vec_t v, input logic [3:0] a);
    case (a)
      4'd0:    return v.e_dev;
      4'd2:    return v.e_lnk;
      4'd3:    return v.e_cmd;
      4'd13:   return v.e_msi;
      4'd15:   return v.e_bd;
      default: return 32'h0;
    endcase
  endfunction

  task automatic wait_req(input int limit, output int lat);
    lat = 0;
    for (int i = 1; i <= limit && lat == 0; i++) begin
      @(negedge clk);
      if (core_msi_req) lat = i;
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_add"}, 64'(tl_cfg_add), 64'h0);
    check({name, "_ctl"}, 64'(tl_cfg_ctl), 64'h0);
    check({name, "_sts"}, 64'(tl_cfg_sts), 64'h0);
    check({name, "_req"}, 64'(core_msi_req), 64'h0);
    check({name, "_ack"}, 64'(app_msi_ack), 64'h0);
    check({name, "_err"}, 64'(msi_timeout_err), 64'h0);
  endtask

  task automatic run_vec(input int n);
    set_cfg(vecs[n]);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 16 * HOLD; c++) begin
      @(negedge clk);
      check($sformatf("vec%0d_ctl_idx%0d", n, tl_cfg_add), 64'(tl_cfg_ctl),
            64'(exp_ctl(vecs[n], tl_cfg_add)));
    end
    check($sformatf("vec%0d_sts", n), 64'(tl_cfg_sts), 64'(vecs[n].e_sts));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int lat, hi, busy, found;
    logic [3:0] exp_add;
    logic [15:0] cid;

    //              bus    dev    mp      mr      rcb   bm    me    lw     lr     dev           lnk           cmd           msi    bd            sts
    vecs[0] = '{8'h05, 5'h03, 3'b001, 3'b010, 1'b1, 1'b1, 1'b1, 6'd4,  4'd2, 32'h2020_0000, 32'h0008_0000, 32'h0400_0000, 32'h1, 32'h0000_00A3, 53'h0021_0000_0000};
    vecs[1] = '{8'hFF, 5'h1F, 3'b101, 3'b111, 1'b0, 1'b0, 1'b0, 6'h3F, 4'hF, 32'h70A0_0000, 32'h0,         32'h0,         32'h0, 32'h0000_1FFF, 53'h01FF_8000_0000};
    vecs[2] = '{8'hA5, 5'h0A, 3'b000, 3'b101, 1'b1, 1'b0, 1'b1, 6'd8,  4'd1, 32'h5000_0000, 32'h0008_0000, 32'h0,         32'h1, 32'h0000_14AA, 53'h0040_8000_0000};
    vecs[3] = '{8'h00, 5'h00, 3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 6'd1,  4'd1, 32'h0040_0000, 32'h0,         32'h0400_0000, 32'h0, 32'h0,          53'h0008_8000_0000};

    // Reset state, then the first sweep counted edge by edge from release.
    set_cfg(vecs[0]);
    #1;
    check_idle_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 17 * HOLD; k++) begin
      @(negedge clk);
      exp_add = 4'((k / HOLD) % 16);
      check($sformatf("sweep_add_k%0d", k), 64'(tl_cfg_add), 64'(exp_add));
      check($sformatf("sweep_ctl_k%0d", k), 64'(tl_cfg_ctl),
            64'((k == 1) ? 32'h0 : exp_ctl(vecs[0], exp_add)));
      if (k == 2) check("sweep_sts", 64'(tl_cfg_sts), 64'(vecs[0].e_sts));
      if (k == 15 * HOLD + 4) begin
        cid = {tl_cfg_ctl[12:5], tl_cfg_ctl[4:0], 3'b000};
        check("completer_id", 64'(cid), 64'h0518);
      end
    end

    for (int n = 0; n < 4; n++) run_vec(n);

    // MSI normal: grant in the fifth REQ cycle.
    set_cfg(vecs[0]);
    repeat (3) @(negedge clk);
    app_msi_req = 1'b1;
    wait_req(10, lat);
    check("msi_req_latency", 64'(lat), 64'd1);
    hi = 1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (core_msi_req) hi++;
      if (i == 4) core_msi_gnt = 1'b1;
    end
    @(negedge clk);
    core_msi_gnt = 1'b0;
    check("msi_req_high_cycles", 64'(hi), 64'd5);
    check("msi_req_drop", 64'(core_msi_req), 64'h0);
    check("msi_ack_pulse", 64'(app_msi_ack), 64'h1);
    @(negedge clk);
    check("msi_ack_single", 64'(app_msi_ack), 64'h0);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      core_msi_gnt = (i == 5);
      @(negedge clk);
      if (core_msi_req || app_msi_ack) busy++;
    end
    core_msi_gnt = 1'b0;
    check("msi_held_level_no_rerequest", 64'(busy), 64'd0);
    app_msi_req = 1'b0;
    repeat (2) @(negedge clk);
    app_msi_req = 1'b1;
    wait_req(10, lat);
    check("msi_second_req_latency", 64'(lat), 64'd1);
    core_msi_gnt = 1'b1;
    @(negedge clk);
    core_msi_gnt = 1'b0;
    check("msi_second_ack", 64'(app_msi_ack), 64'h1);
    app_msi_req = 1'b0;
    repeat (3) @(negedge clk);

    // MSI disabled: request level is ignored.
    set_cfg(vecs[1]);
    repeat (3) @(negedge clk);
    app_msi_req = 1'b1;
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (core_msi_req || app_msi_ack) busy++;
    end
    check("msi_disabled_quiet", 64'(busy), 64'd0);
    app_msi_req = 1'b0;

    // Grant arrives in the same cycle the timeout would fire.
    set_cfg(vecs[0]);
    repeat (3) @(negedge clk);
    app_msi_req = 1'b1;
    wait_req(10, lat);
    check("race_req_latency", 64'(lat), 64'd1);
    hi = 1;
    for (int i = 1; i <= TMO - 1; i++) begin
      @(negedge clk);
      if (core_msi_req) hi++;
      if (i == TMO - 1) core_msi_gnt = 1'b1;
    end
    @(negedge clk);
    core_msi_gnt = 1'b0;
    check("race_req_high_cycles", 64'(hi), 64'(TMO));
    check("race_ack", 64'(app_msi_ack), 64'h1);
    check("race_req_drop", 64'(core_msi_req), 64'h0);
    @(negedge clk);
    check("race_err_clear", 64'(msi_timeout_err), 64'h0);
    app_msi_req = 1'b0;
    repeat (3) @(negedge clk);

    // Timeout: no grant ever arrives.
    app_msi_req = 1'b1;
    wait_req(10, lat);
    check("tmo_req_latency", 64'(lat), 64'd1);
    hi = 1;
    busy = 0;
    for (int i = 0; i < 40 && hi == i + 1; i++) begin
      @(negedge clk);
      if (core_msi_req) hi++;
      if (app_msi_ack) busy++;
    end
    check("tmo_req_high_cycles", 64'(hi), 64'(TMO));
    check("tmo_err_set", 64'(msi_timeout_err), 64'h1);
    app_msi_req = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (app_msi_ack) busy++;
    end
    check("tmo_no_ack", 64'(busy), 64'd0);
    check("tmo_err_sticky", 64'(msi_timeout_err), 64'h1);

    // Asynchronous reset while at index 9 and in REQ.
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (tl_cfg_add == 4'd9) found = 1;
    end
    check("rst_reach_idx9", 64'(found), 64'd1);
    app_msi_req = 1'b1;
    wait_req(4, lat);
    check("rst_req_active", 64'(lat), 64'd1);
    check("rst_pre_idx9", 64'(tl_cfg_add), 64'd9);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    @(negedge clk);
    app_msi_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    busy = 0;
    for (int k = 1; k <= HOLD + 1; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_add_k%0d", k), 64'(tl_cfg_add), 64'((k / HOLD) % 16));
      if (core_msi_req || app_msi_ack) busy++;
    end
    check("post_rst_msi_quiet", 64'(busy), 64'd0);
    app_msi_req = 1'b1;
    wait_req(4, lat);
    check("post_rst_idle_accepts", 64'(lat), 64'd1);
    core_msi_gnt = 1'b1;
    @(negedge clk);
    core_msi_gnt = 1'b0;
    check("post_rst_ack", 64'(app_msi_ack), 64'h1);
    check("post_rst_err", 64'(msi_timeout_err), 64'h0);
    app_msi_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
